singleton_elim_scheduler: RTL and testbench

Shares one singleton-elimination datapath between two graph requesters. Round-robin arbitration picks one 128-bit graph per cycle and drives it into the datapath. A valid/source-tag shift register is matched to the datapath latency. The block returns each nonSingletons/singletonCount result with its source tag on a single valid/ready output, stalling the whole datapath through its clock enable under backpressure. A flush FSM drains in-flight work before a reconfiguration or job boundary.

---
 rtl/singleton_elim_scheduler.sv | 122 ++++++++++++
 tb/tb_singleton_elim_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/singleton_elim_scheduler.sv
// rtl/singleton_elim_scheduler.sv - round-robin share of one singleton-elimination datapath between two requesters
// Define SINGLETON_SCHED_STATS_EN to add saturating traffic and stall counters.
module singleton_elim_scheduler #(
  parameter int DP_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  input  logic [127:0] req_graph0,
  input  logic [127:0] req_graph1,
  output logic [1:0]   req_ready,
  output logic         dp_clkEn,
  output logic [127:0] dp_graph,
  input  logic [127:0] dp_nonSingletons,
  input  logic [5:0]   dp_singletonCount,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_nonSingletons,
  output logic [5:0]   out_singletonCount,
  output logic         out_src,
  input  logic         flush,
  output logic         flush_done,
  output logic         busy
`ifdef SINGLETON_SCHED_STATS_EN
  ,
  output logic [31:0]  stat_graphs0,
  output logic [31:0]  stat_graphs1,
  output logic [39:0]  stat_singletons,
  output logic [31:0]  stat_stall_cycles
`endif
);

  localparam logic [1:0] STATE_RUN   = 2'd0;
  localparam logic [1:0] STATE_DRAIN = 2'd1;
  localparam logic [1:0] STATE_DONE  = 2'd2;

  logic [1:0]            state;
  logic                  lastGrant;
  logic [DP_LATENCY-1:0] tagValid;
  logic [DP_LATENCY-1:0] tagSrc;
  logic                  canIssue;
  logic                  issue;
  logic                  grantSrc;
  logic [1:0]            grant;

  assign out_valid          = tagValid[DP_LATENCY-1];
  assign out_src            = tagSrc[DP_LATENCY-1];
  assign out_nonSingletons  = dp_nonSingletons;
  assign out_singletonCount = dp_singletonCount;
  assign dp_clkEn           = ~(out_valid & ~out_ready);
  assign busy               = |tagValid;
  assign flush_done         = (state == STATE_DONE);
  assign canIssue           = ~rst & dp_clkEn & (state == STATE_RUN) & ~flush;

  always_comb begin
    grant = 2'b00;
    if (canIssue) begin
      if (req_valid == 2'b11) grant = lastGrant ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end

  assign req_ready = grant;
  assign issue     = |grant;
  assign grantSrc  = grant[1];
  assign dp_graph  = grant[1] ? req_graph1 : (grant[0] ? req_graph0 : '0);

  // Tags only move when the datapath does, so they stay aligned with its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagValid <= '0;
      tagSrc   <= '0;
    end else if (dp_clkEn) begin
      tagValid[0] <= issue;
      tagSrc[0]   <= grantSrc;
      for (int i = 1; i < DP_LATENCY; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagSrc[i]   <= tagSrc[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        lastGrant <= 1'b1;
    else if (issue) lastGrant <= grantSrc;
  end

  // An already-empty pipeline skips DRAIN so the done pulse follows the flush by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STATE_RUN;
    end else begin
      case (state)
        STATE_RUN:   if (flush) state <= busy ? STATE_DRAIN : STATE_DONE;
        STATE_DRAIN: if (!busy) state <= STATE_DONE;
        STATE_DONE:  state <= STATE_RUN;
        default:     state <= STATE_RUN;
      endcase
    end
  end

`ifdef SINGLETON_SCHED_STATS_EN
  logic [40:0] singletonSum;
  assign singletonSum = {1'b0, stat_singletons} + 41'(out_singletonCount);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_graphs0      <= '0;
      stat_graphs1      <= '0;
      stat_singletons   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (grant[0] && stat_graphs0 != '1) stat_graphs0 <= stat_graphs0 + 32'd1;
      if (grant[1] && stat_graphs1 != '1) stat_graphs1 <= stat_graphs1 + 32'd1;
      if (out_valid && out_ready)
        stat_singletons <= singletonSum[40] ? '1 : singletonSum[39:0];
      if (!dp_clkEn && stat_stall_cycles != '1) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_singleton_elim_scheduler.sv
// tb/tb_singleton_elim_scheduler.sv - randomized scoreboard bench for singleton_elim_scheduler
// Stats checks are built when SINGLETON_SCHED_STATS_EN is defined.
module tb_singleton_elim_scheduler;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [127:0] req_graph0 = '0;
  logic [127:0] req_graph1 = '0;
  logic         out_ready = 1'b1;
  logic         flush = 1'b0;
  logic [1:0]   req_ready;
  logic         dp_clkEn;
  logic [127:0] dp_graph;
  logic [127:0] dp_nonSingletons;
  logic [5:0]   dp_singletonCount;
  logic         out_valid;
  logic [127:0] out_nonSingletons;
  logic [5:0]   out_singletonCount;
  logic         out_src;
  logic         flush_done;
  logic         busy;
`ifdef SINGLETON_SCHED_STATS_EN
  logic [31:0]  stat_graphs0, stat_graphs1, stat_stall_cycles;
  logic [39:0]  stat_singletons;
`endif

  int passCount = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  singleton_elim_scheduler #(.DP_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_graph0(req_graph0), .req_graph1(req_graph1), .req_ready(req_ready),
    .dp_clkEn(dp_clkEn), .dp_graph(dp_graph),
    .dp_nonSingletons(dp_nonSingletons), .dp_singletonCount(dp_singletonCount),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_nonSingletons(out_nonSingletons), .out_singletonCount(out_singletonCount), .out_src(out_src),
    .flush(flush), .flush_done(flush_done), .busy(busy)
`ifdef SINGLETON_SCHED_STATS_EN
    ,
    .stat_graphs0(stat_graphs0), .stat_graphs1(stat_graphs1),
    .stat_singletons(stat_singletons), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // A graph is 16 nodes of 8 adjacency bits; a node with exactly one edge is a singleton.
  function automatic logic [127:0] nsOf(input logic [127:0] g);
    logic [127:0] r = g;
    for (int b = 0; b < 16; b++)
      if ($countones(g[b*8 +: 8]) == 1) r[b*8 +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [5:0] cntOf(input logic [127:0] g);
    int c = 0;
    for (int b = 0; b < 16; b++)
      if ($countones(g[b*8 +: 8]) == 1) c++;
    return 6'(c);
  endfunction

  function automatic logic [127:0] randGraph();
    logic [127:0] g = '0;
    for (int b = 0; b < 16; b++)
      case ($urandom_range(0, 3))
        0:       g[b*8 +: 8] = 8'h00;
        1:       g[b*8 +: 8] = 8'h01 << $urandom_range(0, 7);
        default: g[b*8 +: 8] = 8'($urandom);
      endcase
    return g;
  endfunction

  // External datapath: L enabled registers in front of the singleton function.
  logic [127:0] dpPipe [L];
  always @(posedge clk)
    if (dp_clkEn) begin
      dpPipe[0] <= dp_graph;
      for (int i = 1; i < L; i++) dpPipe[i] <= dpPipe[i-1];
    end
  assign dp_nonSingletons  = nsOf(dpPipe[L-1]);
  assign dp_singletonCount = cntOf(dpPipe[L-1]);

  // Reference: in-flight graphs stamped with the advance tick at acceptance; a graph is
  // presented once the datapath has advanced L times since it was taken.
  typedef struct { logic src; logic [127:0] g; int t; } item_t;
  item_t q[$];
  int tick = 0;
  int lastG = 1;
  int st = 0;
  logic expOutValid, expClkEn, expBusy, expDone;
  logic [1:0] expReady;
  logic [127:0] expGraph;

  task automatic evalModel();
    expOutValid = (q.size() > 0) && (tick - q[0].t == L);
    expClkEn    = !(expOutValid && !out_ready);
    expBusy     = q.size() > 0;
    expDone     = (st == 2);
    expReady    = 2'b00;
    if (!rst && expClkEn && st == 0 && !flush) begin
      if (req_valid == 2'b11) expReady = (lastG == 1) ? 2'b01 : 2'b10;
      else                    expReady = req_valid;
    end
    expGraph = expReady[1] ? req_graph1 : (expReady[0] ? req_graph0 : '0);
  endtask

  task automatic settle();
    #1;
    evalModel();
  endtask

  task automatic advance();
    item_t it;
    @(posedge clk);
    if (rst) begin
      q.delete();
      st = 0;
      lastG = 1;
    end else begin
      if (expOutValid && out_ready) void'(q.pop_front());
      if (expReady != 2'b00) begin
        it.src = expReady[1];
        it.g   = expReady[1] ? req_graph1 : req_graph0;
        it.t   = tick;
        q.push_back(it);
        lastG = int'(expReady[1]);
      end
      if (expClkEn) tick++;
      case (st)
        0: if (flush) st = expBusy ? 1 : 2;
        1: if (!expBusy) st = 2;
        default: st = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_valid = 2'b00; flush = 1'b0; out_ready = 1'b1;
    settle(); advance();
    settle(); advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    settle();
    totalCount++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready); else passCount++;
    totalCount++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passCount++;
    totalCount++; if (out_src !== 1'b0) $display("FAIL reset_out_src: got %b want 0", out_src); else passCount++;
    totalCount++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passCount++;
    totalCount++; if (flush_done !== 1'b0) $display("FAIL reset_flush_done: got %b want 0", flush_done); else passCount++;
    totalCount++; if (dp_clkEn !== 1'b1) $display("FAIL reset_dp_clkEn: got %b want 1", dp_clkEn); else passCount++;
    totalCount++; if (dp_graph !== 128'h0) $display("FAIL reset_dp_graph: got %h want 0", dp_graph); else passCount++;
  endtask

  task automatic test_single_issue();
    int seen = -1;
    req_valid = 2'b01; req_graph0 = 128'h1;
    settle();
    totalCount++; if (req_ready !== 2'b01) $display("FAIL single_grant: got %b want 01", req_ready); else passCount++;
    advance();
    req_valid = 2'b00;
    for (int k = 1; k <= L + 2; k++) begin
      settle();
      totalCount++; if (out_valid !== expOutValid) $display("FAIL single_out_valid cycle %0d: got %b want %b", k, out_valid, expOutValid); else passCount++;
      if (out_valid) begin
        seen = k;
        totalCount++; if (out_src !== 1'b0) $display("FAIL single_src: got %b want 0", out_src); else passCount++;
        totalCount++; if (out_nonSingletons !== 128'h0) $display("FAIL single_ns: got %h want 0", out_nonSingletons); else passCount++;
        totalCount++; if (out_singletonCount !== 6'd1) $display("FAIL single_count: got %0d want 1", out_singletonCount); else passCount++;
      end
      advance();
    end
    totalCount++; if (seen != L) $display("FAIL single_latency: got %0d want %0d", seen, L); else passCount++;
  endtask

  task automatic test_contention();
    logic order[$];
    logic wantSrc;
    int outCount = 0;
    reset_dut();
    for (int i = 0; i < 14; i++) begin
      req_valid = (i < 6) ? 2'b11 : 2'b00;
      req_graph0 = randGraph(); req_graph1 = randGraph();
      settle();
      if (i < 6) begin
        totalCount++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL contention_grant %0d: got %b want %b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10); else passCount++;
        order.push_back(i % 2 != 0);
      end
      totalCount++; if (out_valid !== expOutValid) $display("FAIL contention_out_valid %0d: got %b want %b", i, out_valid, expOutValid); else passCount++;
      if (out_valid && out_ready) begin
        outCount++;
        wantSrc = (order.size() > 0) ? order.pop_front() : 1'bx;
        totalCount++; if (out_src !== wantSrc) $display("FAIL contention_src: got %b want %b", out_src, wantSrc); else passCount++;
        totalCount++; if (out_nonSingletons !== nsOf(q[0].g) || out_singletonCount !== cntOf(q[0].g)) $display("FAIL contention_data: got %h/%0d want %h/%0d", out_nonSingletons, out_singletonCount, nsOf(q[0].g), cntOf(q[0].g)); else passCount++;
      end
      advance();
    end
    totalCount++; if (outCount != 6) $display("FAIL contention_count: got %0d want 6", outCount); else passCount++;
  endtask

  task automatic test_backpressure();
    int issued = 0, outCount = 0, stalls = 0;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      req_valid = (issued < 4) ? (2'b01 << $urandom_range(0, 1)) : 2'b00;
      req_graph0 = randGraph(); req_graph1 = randGraph();
      out_ready = !(i >= L + 1 && i <= L + 3);
      settle();
      totalCount++; if (dp_clkEn !== expClkEn) $display("FAIL bp_clkEn %0d: got %b want %b", i, dp_clkEn, expClkEn); else passCount++;
      totalCount++; if (out_valid !== expOutValid) $display("FAIL bp_out_valid %0d: got %b want %b", i, out_valid, expOutValid); else passCount++;
      if (dp_clkEn === 1'b0) stalls++;
      if (expReady != 2'b00) issued++;
      if (out_valid && expOutValid) begin
        totalCount++; if (out_src !== q[0].src || out_nonSingletons !== nsOf(q[0].g) || out_singletonCount !== cntOf(q[0].g)) $display("FAIL bp_data %0d: got %b/%h/%0d want %b/%h/%0d", i, out_src, out_nonSingletons, out_singletonCount, q[0].src, nsOf(q[0].g), cntOf(q[0].g)); else passCount++;
        if (out_ready) outCount++;
      end
      advance();
    end
    out_ready = 1'b1;
    totalCount++; if (stalls != 3) $display("FAIL bp_stall_cycles: got %0d want 3", stalls); else passCount++;
    totalCount++; if (outCount != 4) $display("FAIL bp_out_count: got %0d want 4", outCount); else passCount++;
  endtask

  task automatic test_flush();
    int doneAt = -1, pulses = 0, lastHs = -1;
    reset_dut();
    for (int i = 0; i < L; i++) begin
      req_valid = 2'b11; req_graph0 = randGraph(); req_graph1 = randGraph();
      settle(); advance();
    end
    flush = 1'b1;
    for (int k = 0; k < L + 7; k++) begin
      settle();
      if (doneAt < 0) begin
        totalCount++; if (req_ready !== 2'b00) $display("FAIL flush_no_grant %0d: got %b want 00", k, req_ready); else passCount++;
      end
      totalCount++; if (flush_done !== expDone) $display("FAIL flush_done_model %0d: got %b want %b", k, flush_done, expDone); else passCount++;
      if (out_valid && out_ready) lastHs = k;
      if (flush_done) begin
        pulses++;
        if (doneAt < 0) doneAt = k;
        totalCount++; if (busy !== 1'b0) $display("FAIL flush_busy_at_done: got %b want 0", busy); else passCount++;
      end
      advance();
      if (doneAt >= 0) begin flush = 1'b0; req_valid = 2'b00; end
    end
    totalCount++; if (doneAt != L + 1) $display("FAIL flush_full_timing: got %0d want %0d", doneAt, L + 1); else passCount++;
    totalCount++; if (pulses != 1) $display("FAIL flush_pulses: got %0d want 1", pulses); else passCount++;
    totalCount++; if (lastHs < 0 || lastHs >= doneAt) $display("FAIL flush_order: got last handshake %0d want before %0d", lastHs, doneAt); else passCount++;
    flush = 1'b1; req_valid = 2'b11;
    settle();
    totalCount++; if (req_ready !== 2'b00) $display("FAIL flush_empty_block: got %b want 00", req_ready); else passCount++;
    advance();
    flush = 1'b0; req_valid = 2'b00;
    settle();
    totalCount++; if (flush_done !== 1'b1) $display("FAIL flush_empty_timing: got %b want 1", flush_done); else passCount++;
    advance();
    settle();
    totalCount++; if (flush_done !== 1'b0) $display("FAIL flush_empty_single: got %b want 0", flush_done); else passCount++;
  endtask

  task automatic test_reset_mid();
    int outCount = 0;
    reset_dut();
    req_valid = 2'b10; req_graph1 = randGraph(); settle(); advance();
    req_valid = 2'b01; req_graph0 = randGraph(); settle(); advance();
    rst = 1'b1; req_valid = 2'b11;
    settle();
    totalCount++; if (req_ready !== 2'b00) $display("FAIL midreset_grant_in_reset: got %b want 00", req_ready); else passCount++;
    advance();
    rst = 1'b0;
    settle();
    totalCount++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b want 0", out_valid); else passCount++;
    totalCount++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passCount++;
    totalCount++; if (req_ready !== 2'b01) $display("FAIL midreset_tie: got %b want 01", req_ready); else passCount++;
    advance();
    req_valid = 2'b00;
    for (int k = 0; k < L + 3; k++) begin
      settle();
      totalCount++; if (out_valid !== expOutValid) $display("FAIL midreset_drain %0d: got %b want %b", k, out_valid, expOutValid); else passCount++;
      if (out_valid && out_ready) begin
        outCount++;
        totalCount++; if (out_src !== 1'b0) $display("FAIL midreset_src: got %b want 0", out_src); else passCount++;
      end
      advance();
    end
    totalCount++; if (outCount != 1) $display("FAIL midreset_count: got %0d want 1", outCount); else passCount++;
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      req_valid  = 2'($urandom_range(0, 3));
      req_graph0 = randGraph(); req_graph1 = randGraph();
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 29) == 0);
      settle();
      totalCount++; if (req_ready !== expReady) $display("FAIL rand_req_ready %0d: got %b want %b", i, req_ready, expReady); else passCount++;
      totalCount++; if (dp_clkEn !== expClkEn) $display("FAIL rand_clkEn %0d: got %b want %b", i, dp_clkEn, expClkEn); else passCount++;
      totalCount++; if (dp_graph !== expGraph) $display("FAIL rand_dp_graph %0d: got %h want %h", i, dp_graph, expGraph); else passCount++;
      totalCount++; if (out_valid !== expOutValid) $display("FAIL rand_out_valid %0d: got %b want %b", i, out_valid, expOutValid); else passCount++;
      totalCount++; if (busy !== expBusy) $display("FAIL rand_busy %0d: got %b want %b", i, busy, expBusy); else passCount++;
      totalCount++; if (flush_done !== expDone) $display("FAIL rand_flush_done %0d: got %b want %b", i, flush_done, expDone); else passCount++;
      if (out_valid && expOutValid) begin
        totalCount++; if (out_src !== q[0].src || out_nonSingletons !== nsOf(q[0].g) || out_singletonCount !== cntOf(q[0].g)) $display("FAIL rand_data %0d: got %b/%h/%0d want %b/%h/%0d", i, out_src, out_nonSingletons, out_singletonCount, q[0].src, nsOf(q[0].g), cntOf(q[0].g)); else passCount++;
      end
      advance();
    end
    flush = 1'b0; out_ready = 1'b1; req_valid = 2'b00;
  endtask

`ifdef SINGLETON_SCHED_STATS_EN
  task automatic test_stats();
    int sent = 0, stallModel = 0;
    reset_dut();
    for (int i = 0; i < 30; i++) begin
      req_valid  = (sent < 5) ? 2'b10 : 2'b00;
      req_graph1 = 128'hC3000000_00000000_00000000_00804001;
      out_ready  = !(i >= 3 && i < 6);
      settle();
      if (expOutValid && !out_ready) stallModel++;
      if (expReady[1]) sent++;
      advance();
    end
    out_ready = 1'b1;
    settle();
    totalCount++; if (stat_graphs1 !== 32'd5) $display("FAIL stat_graphs1: got %0d want 5", stat_graphs1); else passCount++;
    totalCount++; if (stat_graphs0 !== 32'd0) $display("FAIL stat_graphs0: got %0d want 0", stat_graphs0); else passCount++;
    totalCount++; if (stat_singletons !== 40'd15) $display("FAIL stat_singletons: got %0d want 15", stat_singletons); else passCount++;
    totalCount++; if (stat_stall_cycles !== 32'(stallModel)) $display("FAIL stat_stall_cycles: got %0d want %0d", stat_stall_cycles, stallModel); else passCount++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single_issue();
    test_contention();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef SINGLETON_SCHED_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
